uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; next generation of tx_uart. Adds configurable data width, parity, stop bits,

---
 rtl/uart_tx_param_pkg.sv | 24 ++
 rtl/uart_tx_param_if.sv | 36 +++
 rtl/uart_tx_param_fifo.sv | 47 ++++
 rtl/uart_tx_param.sv | 154 +++++++++++++++
 tb/tb_uart_tx_param.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg: parity encodings, FSM states and parity helper
// shared by the UART transmitter files.
package uart_tx_param_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_e;

   function automatic logic parity_bit(
      input logic [8:0] d,
      input int         mode
   );
      return (mode == PARITY_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: write handshake, status and serial line of the
// UART transmitter.
interface uart_tx_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);

   logic                          tx_enable_signal;
   logic [DATA_BITS-1:0]          tx_data;
   logic                          tx_ready;
   logic                          tx_busy;
   logic                          tx_done_signal;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;
   logic                          tx_out;

   modport master (
      output tx_enable_signal,
      output tx_data,
      input  tx_ready,
      input  tx_busy,
      input  tx_done_signal,
      input  fifo_count,
      input  tx_out
   );

   modport slave (
      input  tx_enable_signal,
      input  tx_data,
      output tx_ready,
      output tx_busy,
      output tx_done_signal,
      output fifo_count,
      output tx_out
   );

endinterface

// File: rtl/uart_tx_param_fifo.sv
// uart_tx_param_fifo: synchronous FIFO; pointers carry an extra MSB
// so full and empty are told apart without a separate flag.
module uart_tx_param_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_push;
   logic             do_pop;

   assign count_o = wr_q - rd_q;
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with input FIFO.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stops.
module uart_tx_param
   import uart_tx_param_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int CLK_DIV     = 868,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_param_if.slave bus
);

   localparam int CW = $clog2(CLK_DIV);

   if (DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY_MODE < 0 || PARITY_MODE > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 ||
       CLK_DIV < 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("uart_tx_param: illegal parameter set");
   end

   tx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;

   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 baud_end;
   logic [DATA_BITS-1:0] head;

   uart_tx_param_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.tx_enable_signal),
      .wdata_i (bus.tx_data),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (bus.fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      pop      = 1'b0;
      baud_end = (cnt_q == CW'(CLK_DIV - 1));
      if (state_q != S_IDLE) cnt_d = baud_end ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = parity_bit(9'(head), PARITY_MODE);
               tx_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_q != 4'(DATA_BITS - 1)) begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  bit_d   = bit_q + 1'b1;
               end else if (PARITY_MODE != PARITY_NONE) begin
                  tx_d    = par_q;
                  state_d = S_PARITY;
               end else begin
                  tx_d    = 1'b1;
                  bit_d   = '0;
                  state_d = S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  // chain the next queued frame with no idle gap
                  if (!empty) begin
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = parity_bit(9'(head), PARITY_MODE);
                     tx_d    = 1'b0;
                     state_d = S_START;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign bus.tx_out         = tx_q;
   assign bus.tx_busy        = (state_q != S_IDLE);
   assign bus.tx_done_signal = done_q;
   assign bus.tx_ready       = !full;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked against a
// frame-schedule model, plus vector table and corner sequences.
module tb_uart_tx_param;

   localparam int CD   = 4;
   localparam int NDUT = 4;
   localparam int DEP  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_on = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       en  [NDUT];
   logic [8:0] din [NDUT];
   int         last_end [NDUT];

   typedef struct {
      int dut;
      int acc;
      int start;
      int data;
   } frm_t;
   frm_t sched[$];

   typedef struct {
      int          dut;
      int          data;
      int          len;
      int          nb;
      logic [15:0] bits;
   } vec_t;
   vec_t vt[6];

   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) if_a ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) if_e ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) if_o ();
   uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(DEP)) if_s ();

   assign if_a.tx_enable_signal = en[0];
   assign if_e.tx_enable_signal = en[1];
   assign if_o.tx_enable_signal = en[2];
   assign if_s.tx_enable_signal = en[3];
   assign if_a.tx_data = din[0][7:0];
   assign if_e.tx_data = din[1][7:0];
   assign if_o.tx_data = din[2][7:0];
   assign if_s.tx_data = din[3][6:0];

   uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
      .CLK_DIV(CD), .FIFO_DEPTH(DEP)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
      .CLK_DIV(CD), .FIFO_DEPTH(DEP)) dut_e (.clk(clk), .rst(rst), .bus(if_e));
   uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
      .CLK_DIV(CD), .FIFO_DEPTH(DEP)) dut_o (.clk(clk), .rst(rst), .bus(if_o));
   uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2),
      .CLK_DIV(CD), .FIFO_DEPTH(DEP)) dut_s (.clk(clk), .rst(rst), .bus(if_s));

   function automatic int db(input int d);
      return (d == 3) ? 7 : 8;
   endfunction

   function automatic int pm(input int d);
      return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
   endfunction

   function automatic int sb(input int d);
      return (d == 3) ? 2 : 1;
   endfunction

   function automatic int flen(input int d);
      return CD * (1 + db(d) + ((pm(d) != 0) ? 1 : 0) + sb(d));
   endfunction

   // bit k of the frame for a byte: start, data LSB first, parity, stops
   function automatic int fbit(input int d, input int data, input int k);
      int ones;
      ones = $countones(data);
      if (k == 0) return 0;
      if (k <= db(d)) return (data >> (k - 1)) & 1;
      if (k == db(d) + 1 && pm(d) != 0)
         return (pm(d) == 1) ? (((ones % 2) == 0) ? 1 : 0) : (ones % 2);
      return 1;
   endfunction

   function automatic void model(input int d, input int c, output int tx,
                                 output int done, output int busy,
                                 output int cnt);
      tx = 1; done = 0; busy = 0; cnt = 0;
      foreach (sched[i]) begin
         if (sched[i].dut == d) begin
            if (c >= sched[i].start && c < sched[i].start + flen(d)) begin
               tx   = fbit(d, sched[i].data, (c - sched[i].start) / CD);
               busy = 1;
            end
            if (c == sched[i].start + flen(d)) done = 1;
            if (sched[i].acc <= c && sched[i].start > c) cnt++;
         end
      end
   endfunction

   task automatic obs(input int d, output int tx, output int done,
                      output int busy, output int rdy, output int cnt);
      case (d)
         0: begin
            tx = int'(if_a.tx_out); done = int'(if_a.tx_done_signal);
            busy = int'(if_a.tx_busy); rdy = int'(if_a.tx_ready);
            cnt = int'(if_a.fifo_count);
         end
         1: begin
            tx = int'(if_e.tx_out); done = int'(if_e.tx_done_signal);
            busy = int'(if_e.tx_busy); rdy = int'(if_e.tx_ready);
            cnt = int'(if_e.fifo_count);
         end
         2: begin
            tx = int'(if_o.tx_out); done = int'(if_o.tx_done_signal);
            busy = int'(if_o.tx_busy); rdy = int'(if_o.tx_ready);
            cnt = int'(if_o.fifo_count);
         end
         default: begin
            tx = int'(if_s.tx_out); done = int'(if_s.tx_done_signal);
            busy = int'(if_s.tx_busy); rdy = int'(if_s.tx_ready);
            cnt = int'(if_s.fifo_count);
         end
      endcase
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // called at a negedge; the write lands on the next posedge
   task automatic put(input int d, input int data);
      int n;
      int m;
      int st;
      n = 0;
      m = data & ((1 << db(d)) - 1);
      foreach (sched[i])
         if (sched[i].dut == d && sched[i].start > cyc) n++;
      if (n < DEP) begin
         st = (cyc + 2 > last_end[d]) ? cyc + 2 : last_end[d];
         sched.push_back('{d, cyc + 1, st, m});
         last_end[d] = st + flen(d);
      end
      en[d]  = 1'b1;
      din[d] = 9'(m);
      @(negedge clk);
      en[d]  = 1'b0;
   endtask

   task automatic model_reset();
      sched.delete();
      for (int d = 0; d < NDUT; d++) last_end[d] = 0;
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < NDUT; d++) begin
            int etx, edone, ebusy, ecnt;
            int atx, adone, abusy, ardy, acnt;
            model(d, cyc, etx, edone, ebusy, ecnt);
            obs(d, atx, adone, abusy, ardy, acnt);
            chk($sformatf("line%0d", d), atx, etx);
            chk($sformatf("done%0d", d), adone, edone);
            chk($sformatf("busy%0d", d), abusy, ebusy);
            chk($sformatf("count%0d", d), acnt, ecnt);
            chk($sformatf("ready%0d", d), ardy, (ecnt < DEP) ? 1 : 0);
         end
         while (sched.size() > 0 &&
                sched[0].start + flen(sched[0].dut) < cyc - 2)
            void'(sched.pop_front());
      end
   end

   initial begin
      int tx, done, busy, rdy, cnt;
      int line[256];
      int k;
      int j;
      int bad;
      int mx;
      int dq[$];
      int seen;
      int bdrop;

      for (int d = 0; d < NDUT; d++) begin
         en[d] = 1'b0;
         din[d] = '0;
         last_end[d] = 0;
      end
      vt[0] = '{0, 'h55, 40, 10, 16'h02AA};
      vt[1] = '{1, 'h07, 44, 11, 16'h060E};
      vt[2] = '{2, 'h07, 44, 11, 16'h040E};
      vt[3] = '{1, 'h00, 44, 11, 16'h0400};
      vt[4] = '{3, 'h41, 40, 10, 16'h0382};
      vt[5] = '{2, 'hFF, 44, 11, 16'h07FE};

      #2 rst = 1'b0;
      @(negedge clk);
      chk_on = 1'b1;
      obs(0, tx, done, busy, rdy, cnt);
      chk("rst_line", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", cnt, 0);
      chk("rst_ready", rdy, 1);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         put(vt[v].dut, vt[v].data);
         k = 0;
         obs(vt[v].dut, tx, done, busy, rdy, cnt);
         while (tx != 0 && k < 20) begin
            @(negedge clk);
            k++;
            obs(vt[v].dut, tx, done, busy, rdy, cnt);
         end
         chk($sformatf("latency_v%0d", v), k, 1);
         j = 0;
         while (j < 200) begin
            obs(vt[v].dut, tx, done, busy, rdy, cnt);
            line[j] = tx;
            if (done == 1) break;
            @(negedge clk);
            j++;
         end
         chk($sformatf("len_v%0d", v), j, vt[v].len);
         for (int i = 0; i < vt[v].nb; i++)
            chk($sformatf("bit%0d_v%0d", i, v), line[CD * i + 2],
                int'(vt[v].bits[i]));
         repeat (3) @(negedge clk);
      end

      put(0, 'hA5);
      put(0, 'h3C);
      put(0, 'hFF);
      seen = 0;
      bdrop = 0;
      for (int i = 0; i < 200 && dq.size() < 3; i++) begin
         obs(0, tx, done, busy, rdy, cnt);
         if (tx == 0) seen = 1;
         if (done == 1) dq.push_back(cyc);
         if (seen == 1 && dq.size() < 3 && busy == 0) bdrop++;
         @(negedge clk);
      end
      chk("b2b_dones", dq.size(), 3);
      chk("b2b_busy_drop", bdrop, 0);
      if (dq.size() == 3) begin
         chk("b2b_gap1", dq[1] - dq[0], 40);
         chk("b2b_gap2", dq[2] - dq[1], 40);
      end
      repeat (3) @(negedge clk);

      put(0, 'h11);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 5; i++) put(0, 'h21 + i);
      obs(0, tx, done, busy, rdy, cnt);
      chk("full_count", cnt, 4);
      chk("full_ready", rdy, 0);
      k = 0;
      for (int i = 0; i < 300 && k < 5; i++) begin
         @(negedge clk);
         obs(0, tx, done, busy, rdy, cnt);
         if (done == 1) k++;
      end
      chk("full_frames", k, 5);
      repeat (3) @(negedge clk);

      put(0, 'h3C);
      @(negedge clk);
      obs(0, tx, done, busy, rdy, cnt);
      chk("rst_fall", tx, 0);
      put(0, 'h99);
      repeat (16) @(negedge clk);
      obs(0, tx, done, busy, rdy, cnt);
      chk("pre_rst_count", cnt, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      obs(0, tx, done, busy, rdy, cnt);
      chk("mid_rst_line", tx, 1);
      chk("mid_rst_count", cnt, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         obs(0, tx, done, busy, rdy, cnt);
         if (tx == 0 || done == 1) bad++;
      end
      chk("post_rst_idle", bad, 0);

      repeat (60) begin
         put($urandom_range(0, NDUT - 1), $urandom_range(0, 511));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      mx = 0;
      for (int d = 0; d < NDUT; d++) if (last_end[d] > mx) mx = last_end[d];
      k = 0;
      while (cyc <= mx + 2 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_in_time", (k < 3000) ? 1 : 0, 1);

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
